dmem_responder: RTL and testbench

Data-memory responder for the MEM stage of the 5-stage RISC-V pipeline. It accepts the load/store requests that the controller's decode path (memory_read / memory_we, f3) drives into MEM, services them after a fixed number of wait states, and returns load data and a one-cycle response. While a request is outstanding it raises `mem_stall` toward hazard control, which freezes every pipeline register. The block owns the RAM array and all byte-lane alignment and sign extension.

---
 rtl/riscv_mem_pkg.sv | 14 +
 rtl/dmem_load_align.sv | 21 ++
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared funct3 codes, store lane enables, responder FSM states and counter width
package riscv_mem_pkg;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W = 4'b1111;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/halfword of a RAM word and zero/sign-extends it
// ports: word (raw RAM word), f3 (load funct3), lo (addr[1:0], already aligned), data (extended result)
module dmem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  f3,
  input  logic [1:0]  lo,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    data = f3 == F3_B  ? {{24{b[7]}}, b} :
           f3 == F3_BU ? {24'b0, b} :
           f3 == F3_H  ? {{16{h[15]}}, h} :
           f3 == F3_HU ? {16'b0, h} : word;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data RAM with fixed wait states, byte lanes and load extension
// ports: clk, rst (async, active high); req_read/req_write/req_f3/req_addr/req_wdata request;
//        rdata/resp_valid/misalign response; mem_stall pipeline freeze
// build option: DMEM_MISALIGN_CHECK_EN flags misaligned accesses instead of force-aligning them
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        mem_stall,
  output logic        misalign
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d, a_addr;
  logic [31:0] wdata_q, wdata_d, a_wdata, rdata_q, rdata_d, wd, word, ld;
  logic [2:0] f3_q, f3_d, a_f3;
  logic wr_q, wr_d, a_wr, mis_q, mis_d;
  logic req, idle, fire, we, is_b, is_h, is_w, bad;
  logic [1:0] lo;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic unused_hi;
  assign unused_hi = ^req_addr[31:AW+2];
  dmem_load_align u_align (.word(word), .f3(a_f3), .lo(lo), .data(ld));
  // In IDLE the live request is used directly so a zero-wait access can commit on acceptance
  always_comb begin
    req = req_read | req_write;
    idle = state_q == S_IDLE;
    a_addr = idle ? req_addr[AW+1:0] : addr_q;
    a_f3 = idle ? req_f3 : f3_q;
    a_wdata = idle ? req_wdata : wdata_q;
    a_wr = idle ? req_write : wr_q;
    is_b = a_wr ? a_f3 == F3_B : a_f3[1:0] == 2'b00;
    is_h = a_wr ? a_f3 == F3_H : a_f3[1:0] == 2'b01;
    is_w = !is_b && !is_h;
`ifdef DMEM_MISALIGN_CHECK_EN
    bad = (is_h && a_addr[0]) || (is_w && a_addr[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    lo = is_w ? 2'b00 : is_h ? {a_addr[1], 1'b0} : a_addr[1:0];
    idx = a_addr[AW+1:2];
    be = is_w ? BE_W : is_h ? (lo[1] ? BE_H_HI : BE_H_LO) : BE_B << lo;
    wd = is_w ? a_wdata : is_h ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
    word = mem[idx];
    fire = (idle && req && WAIT_CYCLES == 0) || (state_q == S_WAIT && cnt_q == CNT_W'(1));
    we = fire && a_wr && !bad;
    state_d = idle ? (req ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
              state_q == S_WAIT ? (fire ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d = idle ? (req ? CNT_W'(WAIT_CYCLES) : cnt_q) : state_q == S_WAIT ? cnt_q - 1'b1 : cnt_q;
    addr_d = idle && req ? req_addr[AW+1:0] : addr_q;
    f3_d = idle && req ? req_f3 : f3_q;
    wdata_d = idle && req ? req_wdata : wdata_q;
    wr_d = idle && req ? req_write : wr_q;
    rdata_d = fire ? (bad ? 32'b0 : a_wr ? rdata_q : ld) : rdata_q;
    mis_d = fire ? bad : mis_q;
    mem_stall = (idle && req) || state_q == S_WAIT;
    resp_valid = state_q == S_RESP;
    rdata = rdata_q;
    misalign = mis_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      f3_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      f3_q <= f3_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
      mis_q <= mis_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder with 2 and 0 wait states
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic resp_valid, mem_stall, misalign;
  logic rd0 = 1'b0, wr0 = 1'b0;
  logic [2:0] f30 = '0;
  logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
  logic rv0, st0, mis0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_read(rd), .req_write(wr), .req_f3(f3), .req_addr(addr),
    .req_wdata(wdata), .rdata(rdata), .resp_valid(resp_valid), .mem_stall(mem_stall), .misalign(misalign)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_read(rd0), .req_write(wr0), .req_f3(f30), .req_addr(addr0),
    .req_wdata(wdata0), .rdata(rdata0), .resp_valid(rv0), .mem_stall(st0), .misalign(mis0)
  );
  typedef struct {
    string name;
    logic rd;
    logic wr;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic chk_data;
    logic [31:0] exp;
    logic exp_mis;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic access(input vec_t t);
    int stalls;
    int lat;
    stalls = 0;
    lat = -1;
    @(negedge clk);
    rd = t.rd; wr = t.wr; f3 = t.f3; addr = t.addr; wdata = t.wdata;
    #1;
    for (int k = 0; k < 16 && lat < 0; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (mem_stall) stalls++;
      if (resp_valid) lat = k;
    end
    chk({t.name, " latency"}, lat, 3);
    chk({t.name, " stall_cycles"}, stalls, 3);
    if (t.chk_data) chk({t.name, " rdata"}, rdata, t.exp);
    chk({t.name, " misalign"}, misalign, t.exp_mis);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    #1;
    chk({t.name, " pulse_end"}, resp_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    int seen;
    vec_t lw;
    v[0]  = '{"sw_10",    0, 1, 3'b010, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0};
    v[1]  = '{"lw_10",    1, 0, 3'b010, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0};
    v[2]  = '{"lb_13",    1, 0, 3'b000, 32'h13,   32'h0,        1, 32'hFFFFFFDE, 0};
    v[3]  = '{"lbu_13",   1, 0, 3'b100, 32'h13,   32'h0,        1, 32'h000000DE, 0};
    v[4]  = '{"lh_12",    1, 0, 3'b001, 32'h12,   32'h0,        1, 32'hFFFFDEAD, 0};
    v[5]  = '{"lhu_10",   1, 0, 3'b101, 32'h10,   32'h0,        1, 32'h0000BEEF, 0};
    v[6]  = '{"sb_11",    0, 1, 3'b000, 32'h11,   32'hFFFFFF55, 0, 32'h0,        0};
    v[7]  = '{"lw_after_sb", 1, 0, 3'b010, 32'h10, 32'h0,       1, 32'hDEAD55EF, 0};
`ifdef DMEM_MISALIGN_CHECK_EN
    v[8]  = '{"lw_mis_12", 1, 0, 3'b010, 32'h12,  32'h0,        1, 32'h0,        1};
`else
    v[8]  = '{"lw_mis_12", 1, 0, 3'b010, 32'h12,  32'h0,        1, 32'hDEAD55EF, 0};
`endif
    v[9]  = '{"sh_12",    0, 1, 3'b001, 32'h12,   32'hAAAA1234, 0, 32'h0,        0};
    v[10] = '{"lw_after_sh", 1, 0, 3'b010, 32'h10, 32'h0,       1, 32'h123455EF, 0};
    v[11] = '{"rdwr_store", 1, 1, 3'b010, 32'h20,  32'h0BADF00D, 0, 32'h0,       0};
    v[12] = '{"lw_wrap",  1, 0, 3'b010, 32'h1020, 32'h0,        1, 32'h0BADF00D, 0};
    v[13] = '{"lb_11",    1, 0, 3'b000, 32'h11,   32'h0,        1, 32'h00000055, 0};
    v[14] = '{"lh_10",    1, 0, 3'b001, 32'h10,   32'h0,        1, 32'h000055EF, 0};
    v[15] = '{"lb_10",    1, 0, 3'b000, 32'h10,   32'h0,        1, 32'hFFFFFFEF, 0};
    repeat (2) @(negedge clk);
    #1;
    chk("reset rdata", rdata, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset misalign", misalign, 0);
    chk("reset mem_stall", mem_stall, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset mem_stall", mem_stall, 0);
    for (int i = 0; i < 16; i++) access(v[i]);
    seen = 0;
    @(negedge clk);
    wr = 1'b1; f3 = 3'b010; addr = 32'h10; wdata = 32'h12345678;
    #1;
    if (resp_valid) seen++;
    @(negedge clk);
    #1;
    if (resp_valid) seen++;
    rst = 1'b1;
    wr = 1'b0;
    #1;
    chk("abort mem_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen++;
    end
    chk("abort resp_count", seen, 0);
    lw = '{"lw_after_abort", 1, 0, 3'b010, 32'h10, 32'h0, 1, 32'h123455EF, 0};
    access(lw);
    @(negedge clk);
    wr0 = 1'b1; f30 = 3'b010; addr0 = 32'h4; wdata0 = 32'hCAFEF00D;
    #1;
    chk("w0 sw stall", st0, 1);
    chk("w0 sw accept_resp", rv0, 0);
    @(negedge clk);
    #1;
    chk("w0 sw resp", rv0, 1);
    chk("w0 sw resp_stall", st0, 0);
    wr0 = 1'b0; rd0 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("w0 lw stall", st0, 1);
      chk("w0 lw accept_resp", rv0, 0);
      @(negedge clk);
      #1;
      chk("w0 lw resp", rv0, 1);
      chk("w0 lw rdata", rdata0, 32'hCAFEF00D);
      chk("w0 lw resp_stall", st0, 0);
    end
    rd0 = 1'b0;
    @(negedge clk);
    #1;
    chk("w0 idle resp", rv0, 0);
    chk("w0 idle stall", st0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
